press_event_ctrl: RTL

Controller that sequences one push-button through debounce, press timing and release, classifying each press as a short press, a long press or an auto-repeat stream. It wraps a two-flop input synchroniser and one shared down-timer. It sits between a raw board button and the application FSMs, which consume its single-cycle event pulses and its `held` level. It replaces ad-hoc per-button long-press logic with one timed state machine.

---
 rtl/press_event_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/press_event_ctrl.sv
// -----------------------------------------------------------------------------
// press_event_ctrl
//
// Push-button sequencer. Synchronises a raw button, debounces press and
// release, and classifies each press as a short press, a long press or
// (optionally) an auto-repeat stream. One shared counter times every phase.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset_sync    in   synchronous, active-high reset
//   in            in   raw button, active-high, asynchronous to clk
//   held          out  debounced "button down" level
//   short_press   out  one-cycle pulse, released before the long-press time
//   long_press    out  one-cycle pulse, long-press time reached
//   repeat_pulse  out  one-cycle pulse per repeat interval while long-held
//                      (the name "repeat" is a reserved word)
//
// Build option:
//   PRESS_AUTO_REPEAT_EN  defined: LONG_HELD issues repeat_pulse every
//                         REP_TICKS cycles. Undefined: repeat_pulse is tied
//                         low and the counter saturates in LONG_HELD.
//
// States:
//   state        | meaning
//   -------------+----------------------------------------------------------
//   ST_IDLE      | button up, waiting for in_sync to rise
//   ST_DEB_PRESS | in_sync high, waiting DEB_TICKS to confirm the press
//   ST_PRESSED   | confirmed press, timing towards the long-press threshold
//   ST_LONG_HELD | long press reached, optionally timing repeat intervals
//   ST_DEB_REL   | in_sync low, waiting DEB_TICKS to confirm the release;
//                | origin_long remembers which held state to return to
// -----------------------------------------------------------------------------

module press_event_ctrl #(
  parameter int CLK_PERIOD_ns = 20,
  parameter int DEBOUNCE_ns   = 5_000_000,
  parameter int LONG_PRESS_ns = 500_000_000,
  parameter int REPEAT_ns     = 100_000_000
) (
  input  logic clk,
  input  logic reset_sync,
  input  logic in,
  output logic held,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int DEB_TICKS  = DEBOUNCE_ns / CLK_PERIOD_ns;
  localparam int LONG_TICKS = LONG_PRESS_ns / CLK_PERIOD_ns;
  localparam int REP_TICKS  = REPEAT_ns / CLK_PERIOD_ns;

  localparam int MAX_DL    = (DEB_TICKS > LONG_TICKS) ? DEB_TICKS : LONG_TICKS;
  localparam int MAX_TICKS = (MAX_DL > REP_TICKS) ? MAX_DL : REP_TICKS;
  // A one-tick configuration would give a zero-width counter; keep one bit.
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  // Zero-tick configurations cannot be timed; refuse to elaborate.
  if (DEB_TICKS < 1) begin : g_deb_zero
    $error("press_event_ctrl: DEBOUNCE_ns must be at least one clock period");
  end
  if (LONG_TICKS < 1) begin : g_long_zero
    $error("press_event_ctrl: LONG_PRESS_ns must be at least one clock period");
  end
  if (REP_TICKS < 1) begin : g_rep_zero
    $error("press_event_ctrl: REPEAT_ns must be at least one clock period");
  end

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_TICKS - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DEB_PRESS = 3'd1,
    ST_PRESSED   = 3'd2,
    ST_LONG_HELD = 3'd3,
    ST_DEB_REL   = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_inc;
  logic              origin_long;
  logic              sync_q1;
  logic              sync_q2;
  logic              in_sync;
  logic              deb_tc;
  logic              long_tc;

  // Two-flop synchroniser; the only place the raw button is sampled.
  always_ff @(posedge clk) begin
    if (reset_sync) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= in;
      sync_q2 <= sync_q1;
    end
  end

  assign in_sync = sync_q2;

  // Saturating increment: the counter never wraps back into a terminal
  // count, which is what makes LONG_HELD safe without the repeat timer.
  assign count_inc = (&count) ? count : count + 1'b1;
  assign deb_tc    = (count == DEB_LAST);
  assign long_tc   = (count == LONG_LAST);

`ifdef PRESS_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP_TICKS - 1);

  logic rep_tc;
  logic repeat_q;

  assign rep_tc       = (count == REP_LAST);
  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      state       <= ST_IDLE;
      count       <= '0;
      origin_long <= 1'b0;
      held        <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
`ifdef PRESS_AUTO_REPEAT_EN
      repeat_q    <= 1'b0;
`endif
    end else begin
      // Pulses last one cycle; the counter advances unless a branch below
      // changes state (or restarts the repeat interval).
      short_press <= 1'b0;
      long_press  <= 1'b0;
`ifdef PRESS_AUTO_REPEAT_EN
      repeat_q    <= 1'b0;
`endif
      count       <= count_inc;

      case (state)
        ST_IDLE: begin
          if (in_sync) begin
            state <= ST_DEB_PRESS;
            count <= '0;
          end
        end

        ST_DEB_PRESS: begin
          if (!in_sync) begin
            state <= ST_IDLE;
            count <= '0;
          end else if (deb_tc) begin
            state <= ST_PRESSED;
            count <= '0;
            held  <= 1'b1;
          end
        end

        ST_PRESSED: begin
          if (!in_sync) begin
            state       <= ST_DEB_REL;
            count       <= '0;
            origin_long <= 1'b0;
          end else if (long_tc) begin
            state      <= ST_LONG_HELD;
            count      <= '0;
            long_press <= 1'b1;
          end
        end

        ST_LONG_HELD: begin
          // Release wins over a coinciding repeat interval.
          if (!in_sync) begin
            state       <= ST_DEB_REL;
            count       <= '0;
            origin_long <= 1'b1;
          end
`ifdef PRESS_AUTO_REPEAT_EN
          else if (rep_tc) begin
            count    <= '0;
            repeat_q <= 1'b1;
          end
`endif
        end

        ST_DEB_REL: begin
          // A bounce back to high resumes the held state with fresh timing;
          // time already spent pressed is deliberately forgotten.
          if (in_sync) begin
            state <= origin_long ? ST_LONG_HELD : ST_PRESSED;
            count <= '0;
          end else if (deb_tc) begin
            state       <= ST_IDLE;
            count       <= '0;
            held        <= 1'b0;
            short_press <= !origin_long;
          end
        end

        default: begin
          state <= ST_IDLE;
          count <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule
